balance_pid: RTL and testbench

- Downstream consumer of the inertial interface's fusion-corrected pitch (`ptch`) and its one-cycle `vld` strobe.
- Runs a PID balance loop on each valid sample: saturated error, overflow-protected integrator, derivative over a sample queue.
- Adds steering from the load-cell difference.
- Produces registered, saturated signed left/right motor speed commands and an overspeed flag for the motor-drive stage.

---
 rtl/balance_pid.sv | 121 ++++++++++++
 tb/tb_balance_pid.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/balance_pid.sv
// Two-stage PID balance loop: stage 1 captures error, derivative and integrator on each
// valid pitch sample, stage 2 turns them into saturated left/right speed commands.
module balance_pid #(
    parameter logic signed [4:0] P_COEFF  = 5'sd12,
    parameter logic signed [5:0] D_COEFF  = 6'sd6,
    parameter int                D_DEPTH  = 2,
    parameter logic [11:0]       FAST_THR = 12'd1792
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic               pwr_up,
    input  logic               rider_off,
    input  logic               steer_en,
    input  logic signed [11:0] ld_cell_diff,
    output logic signed [11:0] lft_spd,
    output logic signed [11:0] rght_spd,
    output logic               too_fast
);

    localparam logic signed [12:0] THR = $signed({1'b0, FAST_THR});

    logic signed [9:0]  err;
    logic signed [9:0]  err_q [D_DEPTH];
    logic signed [9:0]  err_reg;
    logic signed [10:0] diff_full;
    logic signed [6:0]  d_sat;
    logic signed [6:0]  d_diff_reg;
    logic signed [17:0] integ;
    logic signed [17:0] integ_sum;
    logic               integ_ovf;
    logic               vld_d;

    logic signed [14:0] p_term;
    logic signed [11:0] i_term;
    logic signed [12:0] d_term;
    logic signed [11:0] steer_sh;
    logic signed [15:0] steer;
    logic signed [15:0] pid;
    logic signed [15:0] lft_sum;
    logic signed [15:0] rght_sum;
    logic signed [11:0] lft_sat;
    logic signed [11:0] rght_sat;

    function automatic logic signed [11:0] sat12(input logic signed [15:0] v);
        if (v > 16'sd2047)
            return 12'sd2047;
        else if (v < -16'sd2048)
            return 12'sh800;
        else
            return v[11:0];
    endfunction

    function automatic logic over_thr(input logic signed [11:0] v);
        return (13'(v) > THR) || (13'(v) < -THR);
    endfunction

    always_comb begin
        err = ptch[9:0];
        if (ptch > 16'sd511)
            err = 10'sd511;
        else if (ptch < -16'sd512)
            err = 10'sh200;

        diff_full = 11'(err) - 11'(err_q[D_DEPTH-1]);
        d_sat = diff_full[6:0];
        if (diff_full > 11'sd63)
            d_sat = 7'sd63;
        else if (diff_full < -11'sd64)
            d_sat = 7'sh40;
    end

    // Overflow shows up as a sign flip when both addends share a sign.
    assign integ_sum = integ + 18'(err);
    assign integ_ovf = (integ[17] == err[9]) && (integ_sum[17] != integ[17]);

    assign p_term   = 15'(err_reg) * 15'(P_COEFF);
    assign i_term   = integ[17:6];
    assign d_term   = 13'(d_diff_reg) * 13'(D_COEFF);
    assign steer_sh = ld_cell_diff >>> 3;
    assign steer    = steer_en ? 16'(steer_sh) : 16'sd0;
    assign pid      = 16'(p_term) + 16'(i_term) + 16'(d_term);
    assign lft_sum  = pid + steer;
    assign rght_sum = pid - steer;
    assign lft_sat  = sat12(lft_sum);
    assign rght_sat = sat12(rght_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !pwr_up) begin
            err_reg    <= '0;
            d_diff_reg <= '0;
            integ      <= '0;
            vld_d      <= 1'b0;
            lft_spd    <= '0;
            rght_spd   <= '0;
            too_fast   <= 1'b0;
            for (int i = 0; i < D_DEPTH; i++)
                err_q[i] <= '0;
        end else begin
            vld_d <= vld;
            if (vld) begin
                err_reg    <= err;
                d_diff_reg <= d_sat;
                err_q[0]   <= err;
                for (int i = 1; i < D_DEPTH; i++)
                    err_q[i] <= err_q[i-1];
            end
            if (rider_off)
                integ <= '0;
            else if (vld && !integ_ovf)
                integ <= integ_sum;
            if (vld_d) begin
                lft_spd  <= lft_sat;
                rght_spd <= rght_sat;
                too_fast <= over_thr(lft_sat) || over_thr(rght_sat);
            end
        end
    end

endmodule

// File: tb/tb_balance_pid.sv
// Randomized and directed bench for balance_pid against an integer-arithmetic model of the
// balance loop (history queue, range-checked integrator, clamp-based saturation).
module tb_balance_pid;

    localparam int P_C = 12;
    localparam int D_C = 6;
    localparam int DEPTH = 2;
    localparam int THR = 1792;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               vld = 1'b0;
    logic signed [15:0] ptch = '0;
    logic               pwr_up = 1'b0;
    logic               rider_off = 1'b0;
    logic               steer_en = 1'b0;
    logic signed [11:0] ld_cell_diff = '0;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               too_fast;

    int total_checks = 0;
    int bad_checks = 0;

    int m_integ, m_err, m_dd, m_l, m_r, m_tf;
    bit m_pend;
    int m_hist[$];

    balance_pid dut (
        .clk(clk), .rst_n(rst_n), .vld(vld), .ptch(ptch), .pwr_up(pwr_up),
        .rider_off(rider_off), .steer_en(steer_en), .ld_cell_diff(ld_cell_diff),
        .lft_spd(lft_spd), .rght_spd(rght_spd), .too_fast(too_fast)
    );

    always #5 clk = ~clk;

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic checkOutput(string tag, int observed, int expected);
        total_checks++;
        if (observed != expected) begin
            bad_checks++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_integ = 0; m_err = 0; m_dd = 0; m_l = 0; m_r = 0; m_tf = 0; m_pend = 0;
        m_hist = {};
        for (int i = 0; i < DEPTH; i++) m_hist.push_back(0);
    endtask

    // One clock edge of the loop as described behaviourally; outputs use pre-edge values.
    task automatic model_step(bit v, int p, bit pu, bit ro, bit se, int ld);
        int e, pid, st, nxt;
        if (!pu) begin
            model_reset();
            return;
        end
        if (m_pend) begin
            pid  = m_err * P_C + (m_integ >>> 6) + m_dd * D_C;
            st   = se ? (ld >>> 3) : 0;
            m_l  = clamp(pid + st, -2048, 2047);
            m_r  = clamp(pid - st, -2048, 2047);
            m_tf = (iabs(m_l) > THR || iabs(m_r) > THR) ? 1 : 0;
        end
        e = clamp(p, -512, 511);
        if (ro)
            m_integ = 0;
        else if (v) begin
            nxt = m_integ + e;
            if (nxt >= -131072 && nxt <= 131071) m_integ = nxt;
        end
        if (v) begin
            m_dd  = clamp(e - m_hist[DEPTH-1], -64, 63);
            m_err = e;
            m_hist.push_front(e);
            void'(m_hist.pop_back());
        end
        m_pend = v;
    endtask

    // Called at a negedge: drive, clock once, then compare at the following negedge.
    task automatic applyStimulus(bit v, int p, bit pu, bit ro, bit se, int ld);
        vld = v; ptch = 16'(p); pwr_up = pu; rider_off = ro; steer_en = se;
        ld_cell_diff = 12'(ld);
        @(posedge clk);
        model_step(v, int'(ptch), pu, ro, se, int'(ld_cell_diff));
        @(negedge clk);
        checkOutput("lft", int'(lft_spd), m_l);
        checkOutput("rght", int'(rght_spd), m_r);
        checkOutput("too_fast", int'(too_fast), m_tf);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_lft", int'(lft_spd), 0);
        checkOutput("rst_rght", int'(rght_spd), 0);
        checkOutput("rst_tf", int'(too_fast), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int p, ld;
        model_reset();
        #12;
        checkOutput("init_lft", int'(lft_spd), 0);
        checkOutput("init_tf", int'(too_fast), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sample: P 1200 + I 1 + D 378.
        applyStimulus(1, 100, 1, 0, 0, 0);
        checkOutput("t1_early", int'(lft_spd), 0);
        applyStimulus(0, 100, 1, 0, 0, 0);
        checkOutput("t1_lft", int'(lft_spd), 1579);
        checkOutput("t1_rght", int'(rght_spd), 1579);
        checkOutput("t1_tf", int'(too_fast), 0);

        apply_reset();
        applyStimulus(1, 1000, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t2_pos", int'(lft_spd), 2047);
        checkOutput("t2_pos_tf", int'(too_fast), 1);
        apply_reset();
        applyStimulus(1, -1000, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t2_neg", int'(rght_spd), -2048);
        checkOutput("t2_neg_tf", int'(too_fast), 1);

        // Integrator saturates at 256 x 511, then a zero sample exposes I=2044, D=-384.
        apply_reset();
        for (int i = 0; i < 257; i++) applyStimulus(1, 511, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t3_hold", int'(lft_spd), 1660);

        apply_reset();
        applyStimulus(1, 0, 1, 0, 1, 800);
        applyStimulus(0, 0, 1, 0, 1, 800);
        checkOutput("t4_lft", int'(lft_spd), 100);
        checkOutput("t4_rght", int'(rght_spd), -100);

        apply_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 200, 1, 0, 0, 0);
            applyStimulus(0, 0, 1, 0, 0, 0);
        end
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(1, 200, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 300, 0, 0, 0, 0);
        checkOutput("t5_off", int'(lft_spd), 0);
        applyStimulus(0, 0, 1, 0, 0, 0);

        // Derivative window with the integrator held clear.
        apply_reset();
        applyStimulus(1, 0, 1, 1, 0, 0);  applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);  applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(1, 50, 1, 1, 0, 0); applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("t6_d3", int'(lft_spd), 900);
        applyStimulus(1, 50, 1, 1, 0, 0); applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("t6_d4", int'(lft_spd), 900);
        applyStimulus(1, 50, 1, 1, 0, 0); applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("t6_d5", int'(lft_spd), 600);
        applyStimulus(1, 50, 1, 1, 0, 0);
        apply_reset();

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: p = $urandom_range(0, 65535) - 32768;
                1: p = $urandom_range(0, 1400) - 700;
                2: p = $urandom_range(0, 120) - 60;
                default: p = ($urandom_range(0, 1) != 0) ? 511 : -512;
            endcase
            ld = $urandom_range(0, 4095) - 2048;
            if ($urandom_range(0, 199) == 0)
                apply_reset();
            else
                applyStimulus($urandom_range(0, 1) == 1, p, $urandom_range(0, 19) != 0,
                              $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, ld);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
